// File: rtl/wb_initiator_if.sv
// ---------------------------------------------------------------------------
// wb_initiator_if
//   Bundles the client request/response handshake and the Wishbone classic
//   bus used by wb_initiator.
//
//   Client request : req_valid, req_ready, req_addr, req_wdata, req_we, req_sel
//   Client response: resp_valid, resp_ready, resp_rdata, resp_err
//   Wishbone       : wb_adr, wb_datwr, wb_datrd, wb_we, wb_sel, wb_stb,
//                    wb_cyc, wb_ack
//
//   master : the initiator's view (accepts requests, drives the bus)
//   slave  : the environment's view (client plus Wishbone responder)
// ---------------------------------------------------------------------------
interface wb_initiator_if #(
  parameter int addr_width   = 32,
  parameter int data_width   = 32,
  parameter int strobe_width = data_width / 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic [addr_width-1:0]   req_addr;
  logic [data_width-1:0]   req_wdata;
  logic                    req_we;
  logic [strobe_width-1:0] req_sel;

  logic                    resp_valid;
  logic                    resp_ready;
  logic [data_width-1:0]   resp_rdata;
  logic                    resp_err;

  logic [addr_width-1:0]   wb_adr;
  logic [data_width-1:0]   wb_datwr;
  logic [data_width-1:0]   wb_datrd;
  logic                    wb_we;
  logic [strobe_width-1:0] wb_sel;
  logic                    wb_stb;
  logic                    wb_cyc;
  logic                    wb_ack;

  modport master (
    input  req_valid, req_addr, req_wdata, req_we, req_sel,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output wb_adr, wb_datwr, wb_we, wb_sel, wb_stb, wb_cyc,
    input  wb_datrd, wb_ack
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_we, req_sel,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  wb_adr, wb_datwr, wb_we, wb_sel, wb_stb, wb_cyc,
    output wb_datrd, wb_ack
  );
endinterface

// File: rtl/wb_initiator.sv
// ---------------------------------------------------------------------------
// wb_initiator
//   Wishbone classic-cycle initiator. Turns one valid/ready client request
//   into a single Wishbone read or write, returns the result on a
//   valid/ready response channel, and aborts with resp_err if the responder
//   does not acknowledge within timeout_cycles cycles (0 = never abort).
//   Only one transaction is ever outstanding.
//
// Ports
//   clock : rising-edge clock for all state
//   reset : asynchronous, active-low reset
//   bus   : wb_initiator_if.master
//             req_*  client request  (req_ready driven here)
//             resp_* client response (resp_ready from client)
//             wb_*   Wishbone bus    (wb_datrd / wb_ack from responder)
// ---------------------------------------------------------------------------
module wb_initiator #(
  parameter int addr_width     = 32,
  parameter int data_width     = 32,
  parameter int strobe_width   = data_width / 8,
  parameter int timeout_cycles = 16
) (
  input  logic            clock,
  input  logic            reset,
  wb_initiator_if.master  bus
);

  localparam int CNT_W = $clog2(timeout_cycles) + 1;
  localparam bit TIMEOUT_EN = (timeout_cycles != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((timeout_cycles > 0) ? timeout_cycles - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                    cyc_stb_q, cyc_stb_d;
  logic [addr_width-1:0]   adr_q,     adr_d;
  logic [data_width-1:0]   datwr_q,   datwr_d;
  logic                    we_q,      we_d;
  logic [strobe_width-1:0] sel_q,     sel_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic [data_width-1:0]   rdata_q,   rdata_d;
  logic                    err_q,     err_d;

  // Last no-ack cycle before the abort; an ack on this same edge still wins
  // because the ack branch is tested first below.
  logic timeout_hit;
  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.req_valid)                state_d = BUS;
      BUS:  if (bus.wb_ack || timeout_hit)    state_d = RESP;
      RESP: if (bus.resp_ready)               state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  // Output / datapath next-state logic. The bus address, data, we and sel
  // only change when a request is accepted, so they stay stable for the
  // whole cycle and across the response phase.
  always_comb begin
    cyc_stb_d = cyc_stb_q;
    adr_d     = adr_q;
    datwr_d   = datwr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          adr_d     = bus.req_addr;
          datwr_d   = bus.req_wdata;
          we_d      = bus.req_we;
          sel_d     = bus.req_sel;
          cyc_stb_d = 1'b1;
          cnt_d     = '0;
        end
      end
      BUS: begin
        if (bus.wb_ack) begin
          cyc_stb_d = 1'b0;
          rdata_d   = we_q ? '0 : bus.wb_datrd;
          err_d     = 1'b0;
        end else if (timeout_hit) begin
          cyc_stb_d = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered bus / response outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc_stb_q <= 1'b0;
      adr_q     <= '0;
      datwr_q   <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      cyc_stb_q <= cyc_stb_d;
      adr_q     <= adr_d;
      datwr_q   <= datwr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign bus.wb_cyc   = cyc_stb_q;
  assign bus.wb_stb   = cyc_stb_q;
  assign bus.wb_adr   = adr_q;
  assign bus.wb_datwr = datwr_q;
  assign bus.wb_we    = we_q;
  assign bus.wb_sel   = sel_q;

endmodule

// File: tb/tb_wb_initiator.sv
// ---------------------------------------------------------------------------
// tb_wb_initiator
//   Bench for wb_initiator: a small SRAM-like Wishbone responder with a
//   configurable ack delay (or no ack at all), a table of directed vectors,
//   hand-written corner sequences and randomized traffic checked against a
//   word-array memory model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;
  localparam int NV = 11;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  wb_initiator_if #(.addr_width(AW), .data_width(DW), .strobe_width(SW)) bus();

  wb_initiator #(
    .addr_width(AW), .data_width(DW), .strobe_width(SW), .timeout_cycles(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- responder ----------------
  logic [31:0] sram [0:15];
  logic        ack_q;
  logic        stray_ack;
  logic        mem_clr;
  logic        resp_dead;
  logic [31:0] dat_q;
  int          resp_dly;
  int          wait_q;

  assign bus.wb_ack   = ack_q | stray_ack;
  assign bus.wb_datrd = dat_q;

  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) sram[i] <= '0;
      ack_q  <= 1'b0;
      wait_q <= 0;
      dat_q  <= '0;
    end else if (!(bus.wb_cyc && bus.wb_stb)) begin
      ack_q  <= 1'b0;
      wait_q <= 0;
    end else if (ack_q) begin
      ack_q <= 1'b0;
    end else if (!resp_dead && wait_q >= resp_dly) begin
      ack_q  <= 1'b1;
      wait_q <= 0;
      if (bus.wb_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.wb_sel[b]) sram[bus.wb_adr[5:2]][8*b +: 8] <= bus.wb_datwr[8*b +: 8];
        dat_q <= '0;
      end else begin
        dat_q <= sram[bus.wb_adr[5:2]];
      end
    end else begin
      wait_q <= wait_q + 1;
    end
  end

  // ---------------- bus activity monitor ----------------
  int cyc_cnt = 0;
  int ack_cnt = 0;
  always @(negedge clock) begin
    if (bus.wb_cyc && bus.wb_stb) cyc_cnt <= cyc_cnt + 1;
    if (bus.wb_cyc && bus.wb_stb && bus.wb_ack) ack_cnt <= ack_cnt + 1;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:15];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // ---------------- checking ----------------
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          dly;
    bit          dead;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_cyc;
  } vec_t;

  vec_t vt [NV];

  // Starts and ends at a negedge. lat counts the cycle index (after the
  // acceptance edge) in which resp_valid is first seen.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 100) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic handshake(input int hold);
    repeat (hold) @(negedge clock);
    bus.resp_ready = 1'b1;
    @(negedge clock);
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input int dly, input bit dead, input int hold,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int ncyc, output int nack);
    int n;
    int c0;
    int a0;
    resp_dly  = dly;
    resp_dead = dead;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_sel   = s;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    c0 = cyc_cnt;
    a0 = ack_cnt;
    @(negedge clock);
    bus.req_valid = 1'b0;
    wait_resp(lat);
    rd   = bus.resp_rdata;
    er   = bus.resp_err;
    ncyc = cyc_cnt - c0;
    nack = ack_cnt - a0;
    handshake(hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, nc, na;
    logic [31:0] exp_rd;

    //           we    addr      wdata          sel  dly dead exp_rdata      err  lat cyc
    vt[0]  = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF,  0, 1'b0, 32'h0,        1'b0,  3,  2};
    vt[1]  = '{1'b0, 32'h10, 32'h0,        4'hF,  0, 1'b0, 32'hDEADBEEF, 1'b0,  3,  2};
    vt[2]  = '{1'b1, 32'h10, 32'h000000AA, 4'h1,  0, 1'b0, 32'h0,        1'b0,  3,  2};
    vt[3]  = '{1'b0, 32'h10, 32'h0,        4'hF,  0, 1'b0, 32'hDEADBEAA, 1'b0,  3,  2};
    vt[4]  = '{1'b1, 32'h14, 32'h12345678, 4'hC,  2, 1'b0, 32'h0,        1'b0,  5,  4};
    vt[5]  = '{1'b0, 32'h14, 32'h0,        4'hF,  1, 1'b0, 32'h12340000, 1'b0,  4,  3};
    vt[6]  = '{1'b0, 32'h10, 32'h0,        4'hF,  0, 1'b1, 32'h0,        1'b1, 17, 16};
    vt[7]  = '{1'b1, 32'h10, 32'hFFFFFFFF, 4'hF,  0, 1'b1, 32'h0,        1'b1, 17, 16};
    vt[8]  = '{1'b0, 32'h10, 32'h0,        4'hF, 14, 1'b0, 32'hDEADBEAA, 1'b0, 17, 16};
    vt[9]  = '{1'b1, 32'h18, 32'hCAFEF00D, 4'h6,  0, 1'b0, 32'h0,        1'b0,  3,  2};
    vt[10] = '{1'b0, 32'h18, 32'h0,        4'hF,  0, 1'b0, 32'h00FEF000, 1'b0,  3,  2};

    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_we     = 1'b0;
    bus.req_sel    = '0;
    bus.resp_ready = 1'b0;
    stray_ack = 1'b0;
    resp_dead = 1'b0;
    resp_dly  = 0;
    mem_clr   = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_cyc",        32'(bus.wb_cyc),     32'd0);
    chk("rst_stb",        32'(bus.wb_stb),     32'd0);
    chk("rst_we",         32'(bus.wb_we),      32'd0);
    chk("rst_adr",        bus.wb_adr,          32'd0);
    chk("rst_datwr",      bus.wb_datwr,        32'd0);
    chk("rst_sel",        32'(bus.wb_sel),     32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata,      32'd0);
    chk("rst_resp_err",   32'(bus.resp_err),   32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset   = 1'b1;
    mem_clr = 1'b0;
    @(negedge clock);
    chk("req_ready_after_reset", 32'(bus.req_ready), 32'd1);

    // ---------------- directed table ----------------
    for (int i = 0; i < NV; i++) begin
      do_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].sel, vt[i].dly, vt[i].dead, 0,
             rd, er, lat, nc, na);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(vt[i].exp_err));
      chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_cyc_cycles", i), nc, vt[i].exp_cyc);
      chk($sformatf("v%0d_ack_cycles", i), na, vt[i].dead ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_idle_ready", i), 32'(bus.req_ready), 32'd1);
      chk($sformatf("v%0d_idle_valid", i), 32'(bus.resp_valid), 32'd0);
      if (!vt[i].dead && vt[i].we)
        ref_mem[vt[i].addr[5:2]] = merge(ref_mem[vt[i].addr[5:2]], vt[i].wdata, vt[i].sel);
    end

    // ---------------- response held off, pending request, stray ack ----------------
    resp_dly = 0;
    resp_dead = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = 32'h10;
    bus.req_sel = 4'hF;
    bus.req_valid = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    wait_resp(lat);
    chk("hold_latency", lat, 32'd3);
    bus.req_we = 1'b1;
    bus.req_addr = 32'h1C;
    bus.req_wdata = 32'h00000055;
    bus.req_sel = 4'hF;
    bus.req_valid = 1'b1;
    stray_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("hold%0d_valid", k), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("hold%0d_rdata", k), bus.resp_rdata, ref_mem[4]);
      chk($sformatf("hold%0d_err", k), 32'(bus.resp_err), 32'd0);
      chk($sformatf("hold%0d_req_ready", k), 32'(bus.req_ready), 32'd0);
      chk($sformatf("hold%0d_cyc", k), 32'(bus.wb_cyc), 32'd0);
    end
    stray_ack = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clock);
    bus.resp_ready = 1'b0;
    chk("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
    chk("post_hs_valid", 32'(bus.resp_valid), 32'd0);
    chk("post_hs_no_cyc", 32'(bus.wb_cyc), 32'd0);
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("pending_accepted_cyc", 32'(bus.wb_cyc), 32'd1);
    chk("pending_adr", bus.wb_adr, 32'h1C);
    wait_resp(lat);
    chk("pending_err", 32'(bus.resp_err), 32'd0);
    chk("pending_rdata", bus.resp_rdata, 32'd0);
    handshake(0);
    ref_mem[7] = merge(ref_mem[7], 32'h00000055, 4'hF);

    // ---------------- randomized traffic ----------------
    for (int t = 0; t < 40; t++) begin
      logic        rwe;
      logic [3:0]  ridx;
      logic [31:0] rwd;
      logic [3:0]  rsel;
      int          rdly;
      bit          rdead;
      rwe   = 1'($urandom_range(0, 1));
      ridx  = 4'($urandom_range(0, 15));
      rwd   = $urandom;
      rsel  = 4'($urandom_range(0, 15));
      rdly  = $urandom_range(0, 3);
      rdead = ($urandom_range(0, 7) == 0);
      do_txn(rwe, {26'd0, ridx, 2'b00}, rwd, rsel, rdly, rdead, $urandom_range(0, 2),
             rd, er, lat, nc, na);
      exp_rd = (rdead || rwe) ? 32'd0 : ref_mem[ridx];
      chk($sformatf("rnd%0d_rdata", t), rd, exp_rd);
      chk($sformatf("rnd%0d_err", t), 32'(er), rdead ? 32'd1 : 32'd0);
      chk($sformatf("rnd%0d_latency", t), lat, rdead ? 32'd17 : 32'(3 + rdly));
      if (!rdead && rwe) ref_mem[ridx] = merge(ref_mem[ridx], rwd, rsel);
    end

    // ---------------- reset in the middle of a bus cycle ----------------
    resp_dead = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = 32'h10;
    bus.req_sel = 4'hF;
    bus.req_valid = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    chk("midrst_cyc_before", 32'(bus.wb_cyc), 32'd1);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("midrst_cyc_async", 32'(bus.wb_cyc), 32'd0);
    chk("midrst_stb_async", 32'(bus.wb_stb), 32'd0);
    chk("midrst_adr", bus.wb_adr, 32'd0);
    chk("midrst_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    resp_dead = 1'b0;
    stray_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("late_ack%0d_ready", k), 32'(bus.req_ready), 32'd1);
      chk($sformatf("late_ack%0d_valid", k), 32'(bus.resp_valid), 32'd0);
      chk($sformatf("late_ack%0d_cyc", k), 32'(bus.wb_cyc), 32'd0);
    end
    stray_ack = 1'b0;
    do_txn(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, 0, rd, er, lat, nc, na);
    chk("after_rst_rdata", rd, ref_mem[4]);
    chk("after_rst_err", 32'(er), 32'd0);
    chk("after_rst_latency", lat, 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
